// File: rtl/rf_writeback_arbiter_pkg.sv
// Shared definitions for the integer register-file write-back path.
package rf_writeback_arbiter_pkg;

  // Default geometry of the integer register file and its LSU result queue.
  localparam int RF_AW    = 5;
  localparam int RF_DW    = 32;
  localparam int RF_DEPTH = 4;

  // Register x0 is hard-wired to zero: never written, never forwarded.
  localparam logic [RF_AW-1:0] RF_X0 = '0;

endpackage

// File: rtl/rf_wb_entry_q.sv
// Circular LSU result queue. Each slot carries a valid bit that an ALU write
// to the same register can clear (WAW kill); killed slots stay occupied until
// popped. Two lookup ports return the youngest still-valid matching entry.
module rf_wb_entry_q
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int AW    = RF_AW,
  parameter int DW    = RF_DW,
  parameter int DEPTH = RF_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enq,
  input  logic [AW-1:0] i_enq_addr,
  input  logic [DW-1:0] i_enq_data,
  input  logic          i_kill,
  input  logic [AW-1:0] i_kill_addr,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_head_occ,
  output logic          o_head_valid,
  output logic [AW-1:0] o_head_addr,
  output logic [DW-1:0] o_head_data,
  input  logic [AW-1:0] i_look1_addr,
  output logic          o_look1_hit,
  output logic [DW-1:0] o_look1_data,
  input  logic [AW-1:0] i_look2_addr,
  output logic          o_look2_hit,
  output logic [DW-1:0] o_look2_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    w_slot [DEPTH];

  // w_slot[k] is the physical slot holding the k-th oldest entry.
  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    assign w_slot[k] = r_rptr + PW'(k);
  end

  assign o_full       = (r_count == CW'(DEPTH));
  assign o_head_occ   = (r_count != '0);
  assign o_head_valid = r_valid[r_rptr];
  assign o_head_addr  = r_addr[r_rptr];
  assign o_head_data  = r_data[r_rptr];

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_enq) r_wptr <= r_wptr + 1'b1;
      if (i_pop) r_rptr <= r_rptr + 1'b1;
      if (i_enq && !i_pop)      r_count <= r_count + 1'b1;
      else if (!i_enq && i_pop) r_count <= r_count - 1'b1;
    end
  end

  // Per-slot valid: cleared by pop or kill; a same-cycle enqueue is older than
  // the ALU write, so it is born killed when the addresses match.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill && r_addr[i] == i_kill_addr) r_valid[i] <= 1'b0;
        if (i_pop && r_rptr == PW'(i))           r_valid[i] <= 1'b0;
        if (i_enq && r_wptr == PW'(i))
          r_valid[i] <= !(i_kill && i_enq_addr == i_kill_addr);
      end
    end
  end

  // Payload storage needs no reset: it is only observed through valid bits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_enq && r_wptr == PW'(i)) begin
        r_addr[i] <= i_enq_addr;
        r_data[i] <= i_enq_data;
      end
    end
  end

  // Youngest-match CAM: scan oldest to youngest so the last match wins.
  always_comb begin
    o_look1_hit  = 1'b0;
    o_look1_data = '0;
    o_look2_hit  = 1'b0;
    o_look2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_valid[w_slot[k]] && r_addr[w_slot[k]] == i_look1_addr && i_look1_addr != '0) begin
        o_look1_hit  = 1'b1;
        o_look1_data = r_data[w_slot[k]];
      end
      if (r_valid[w_slot[k]] && r_addr[w_slot[k]] == i_look2_addr && i_look2_addr != '0) begin
        o_look2_hit  = 1'b1;
        o_look2_data = r_data[w_slot[k]];
      end
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-back arbiter: the ALU owns the write port whenever it
// writes; queued LSU results drain on idle cycles. Pending values (queue and
// output register) are forwarded to decode.
// Handshake: an LSU result transfers on a cycle where lsu_valid && lsu_ready;
// lsu_ready is !full of the registered queue state and is low during reset.
// The ALU side has no backpressure.
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_AW,
  parameter int DATA_WIDTH = RF_DW,
  parameter int DEPTH      = RF_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  wb_full,
  output logic                  rd_wen,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] fw1_addr,
  output logic                  fw1_hit,
  output logic [DATA_WIDTH-1:0] fw1_data,
  input  logic [ADDR_WIDTH-1:0] fw2_addr,
  output logic                  fw2_hit,
  output logic [DATA_WIDTH-1:0] fw2_data
);

  logic                  w_alu_wr;
  logic                  w_enq;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_head_occ;
  logic                  w_head_valid;
  logic [ADDR_WIDTH-1:0] w_head_addr;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic                  w_q1_hit;
  logic [DATA_WIDTH-1:0] w_q1_data;
  logic                  w_q2_hit;
  logic [DATA_WIDTH-1:0] w_q2_data;
  logic                  w_o1_hit;
  logic                  w_o2_hit;

  // Writes to x0 are discarded: ALU ones never reach the port, LSU ones
  // complete the handshake but are not enqueued.
  assign w_alu_wr  = alu_valid && (alu_addr != '0);
  assign lsu_ready = !reset && !w_full;
  assign w_enq     = lsu_valid && lsu_ready && (lsu_addr != '0);
  assign w_pop     = !w_alu_wr && w_head_occ;
  assign wb_full   = w_full;

  rf_wb_entry_q #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_q (
    .clk          (clk),
    .reset        (reset),
    .i_enq        (w_enq),
    .i_enq_addr   (lsu_addr),
    .i_enq_data   (lsu_data),
    .i_kill       (w_alu_wr),
    .i_kill_addr  (alu_addr),
    .i_pop        (w_pop),
    .o_full       (w_full),
    .o_head_occ   (w_head_occ),
    .o_head_valid (w_head_valid),
    .o_head_addr  (w_head_addr),
    .o_head_data  (w_head_data),
    .i_look1_addr (fw1_addr),
    .o_look1_hit  (w_q1_hit),
    .o_look1_data (w_q1_data),
    .i_look2_addr (fw2_addr),
    .o_look2_hit  (w_q2_hit),
    .o_look2_data (w_q2_data)
  );

  // Output register: ALU first, then a valid head; a killed head pops silently
  // and addr/data hold their last written values when nothing is written.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_wen  <= 1'b0;
      rd_addr <= '0;
      rd_data <= '0;
    end else if (w_alu_wr) begin
      rd_wen  <= 1'b1;
      rd_addr <= alu_addr;
      rd_data <= alu_data;
    end else if (w_head_valid) begin
      rd_wen  <= 1'b1;
      rd_addr <= w_head_addr;
      rd_data <= w_head_data;
    end else begin
      rd_wen  <= 1'b0;
    end
  end

  assign w_o1_hit = rd_wen && (rd_addr == fw1_addr) && (fw1_addr != '0);
  assign w_o2_hit = rd_wen && (rd_addr == fw2_addr) && (fw2_addr != '0);

  // Forwarding mux: queued value is younger than the output register.
  always_comb begin
    fw1_hit  = 1'b0;
    fw1_data = '0;
    fw2_hit  = 1'b0;
    fw2_data = '0;
    if (!reset) begin
      if (w_q1_hit) begin
        fw1_hit  = 1'b1;
        fw1_data = w_q1_data;
      end else if (w_o1_hit) begin
        fw1_hit  = 1'b1;
        fw1_data = rd_data;
      end
      if (w_q2_hit) begin
        fw2_hit  = 1'b1;
        fw2_data = w_q2_data;
      end else if (w_o2_hit) begin
        fw2_hit  = 1'b1;
        fw2_data = rd_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: one task per scenario, inline checks.
module tb_rf_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_addr;
  logic [31:0] lsu_data;
  logic        wb_full;
  logic        rd_wen;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [4:0]  fw1_addr;
  logic        fw1_hit;
  logic [31:0] fw1_data;
  logic [4:0]  fw2_addr;
  logic        fw2_hit;
  logic [31:0] fw2_data;

  int checks = 0;
  int errors = 0;

  rf_writeback_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_addr  (lsu_addr),
    .lsu_data  (lsu_data),
    .wb_full   (wb_full),
    .rd_wen    (rd_wen),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .fw1_addr  (fw1_addr),
    .fw1_hit   (fw1_hit),
    .fw1_data  (fw1_data),
    .fw2_addr  (fw2_addr),
    .fw2_hit   (fw2_hit),
    .fw2_data  (fw2_data)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_valid = av; alu_addr = aa; alu_data = ad;
    lsu_valid = lv; lsu_addr = la; lsu_data = ld;
  endtask

  task automatic idle();
    set_in(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); fw1_addr = 5'd0; fw2_addr = 5'd0;
    tick(); tick();
    checks++; if (lsu_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset act=%b req=0", lsu_ready); end
    reset = 1'b0;
    tick();
    checks++; if (rd_wen !== 1'b0) begin errors++; $display("FAIL rst_wen act=%b req=0", rd_wen); end
    checks++; if (rd_addr !== 5'd0) begin errors++; $display("FAIL rst_addr act=%0d req=0", rd_addr); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL rst_data act=%h req=0", rd_data); end
    checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL rst_ready act=%b req=1", lsu_ready); end
    checks++; if (wb_full !== 1'b0) begin errors++; $display("FAIL rst_full act=%b req=0", wb_full); end
    checks++; if (fw1_hit !== 1'b0) begin errors++; $display("FAIL rst_fw1_hit act=%b req=0", fw1_hit); end
  endtask

  task automatic test_lsu_single();
    set_in(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h11);
    tick();
    idle(); fw1_addr = 5'd5; #1;
    checks++; if (rd_wen !== 1'b0) begin errors++; $display("FAIL lsu1_wen_early act=%b req=0", rd_wen); end
    checks++; if (fw1_hit !== 1'b1 || fw1_data !== 32'h11) begin errors++; $display("FAIL lsu1_fw_queue act=%b/%h req=1/11", fw1_hit, fw1_data); end
    tick();
    checks++; if (rd_wen !== 1'b1 || rd_addr !== 5'd5 || rd_data !== 32'h11) begin errors++; $display("FAIL lsu1_write act=%b/%0d/%h req=1/5/11", rd_wen, rd_addr, rd_data); end
    checks++; if (fw1_hit !== 1'b1 || fw1_data !== 32'h11) begin errors++; $display("FAIL lsu1_fw_outreg act=%b/%h req=1/11", fw1_hit, fw1_data); end
    tick();
    checks++; if (rd_wen !== 1'b0) begin errors++; $display("FAIL lsu1_wen_after act=%b req=0", rd_wen); end
    checks++; if (fw1_hit !== 1'b0 || fw1_data !== 32'd0) begin errors++; $display("FAIL lsu1_fw_gone act=%b/%h req=0/0", fw1_hit, fw1_data); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 5'(20 + i), 32'h200 + i, 1'b1, 5'(10 + i), 32'h100 + i);
      tick();
      checks++; if (rd_wen !== 1'b1 || rd_addr !== 5'(20 + i) || rd_data !== 32'h200 + i) begin errors++; $display("FAIL fill_alu%0d act=%b/%0d/%h req=1/%0d/%h", i, rd_wen, rd_addr, rd_data, 20 + i, 32'h200 + i); end
    end
    checks++; if (wb_full !== 1'b1 || lsu_ready !== 1'b0) begin errors++; $display("FAIL fill_full act=%b/%b req=1/0", wb_full, lsu_ready); end
    fw2_addr = 5'd12; #1;
    checks++; if (fw2_hit !== 1'b1 || fw2_data !== 32'h102) begin errors++; $display("FAIL fill_fw2 act=%b/%h req=1/102", fw2_hit, fw2_data); end
    // Offer a fifth result while full: it must not transfer.
    set_in(1'b1, 5'd24, 32'h204, 1'b1, 5'd14, 32'h114);
    tick();
    checks++; if (rd_addr !== 5'd24 || wb_full !== 1'b1) begin errors++; $display("FAIL full_hold act=%0d/%b req=24/1", rd_addr, wb_full); end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_wen !== 1'b1 || rd_addr !== 5'(10 + i) || rd_data !== 32'h100 + i) begin errors++; $display("FAIL drain%0d act=%b/%0d/%h req=1/%0d/%h", i, rd_wen, rd_addr, rd_data, 10 + i, 32'h100 + i); end
      if (i == 0) begin
        checks++; if (lsu_ready !== 1'b1) begin errors++; $display("FAIL drain_ready act=%b req=1", lsu_ready); end
      end
    end
    tick();
    checks++; if (rd_wen !== 1'b0 || rd_addr !== 5'd13 || rd_data !== 32'h103) begin errors++; $display("FAIL drain_empty act=%b/%0d/%h req=0/13/103", rd_wen, rd_addr, rd_data); end
  endtask

  task automatic test_kill();
    fw1_addr = 5'd7;
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'hA);
    tick();
    checks++; if (fw1_hit !== 1'b1 || fw1_data !== 32'hA) begin errors++; $display("FAIL kill_fw_pre act=%b/%h req=1/a", fw1_hit, fw1_data); end
    set_in(1'b1, 5'd7, 32'hB, 1'b0, 5'd0, 32'd0);
    tick();
    checks++; if (rd_wen !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 32'hB) begin errors++; $display("FAIL kill_alu act=%b/%0d/%h req=1/7/b", rd_wen, rd_addr, rd_data); end
    checks++; if (fw1_hit !== 1'b1 || fw1_data !== 32'hB) begin errors++; $display("FAIL kill_fw_post act=%b/%h req=1/b", fw1_hit, fw1_data); end
    idle();
    tick();
    checks++; if (rd_wen !== 1'b0 || rd_addr !== 5'd7 || rd_data !== 32'hB) begin errors++; $display("FAIL kill_skip act=%b/%0d/%h req=0/7/b", rd_wen, rd_addr, rd_data); end
    tick();
    checks++; if (rd_wen !== 1'b0 || fw1_hit !== 1'b0) begin errors++; $display("FAIL kill_idle act=%b/%b req=0/0", rd_wen, fw1_hit); end
  endtask

  task automatic test_youngest();
    fw1_addr = 5'd3;
    set_in(1'b1, 5'd1, 32'h1, 1'b1, 5'd3, 32'd1);
    tick();
    set_in(1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 32'd2);
    tick();
    checks++; if (fw1_hit !== 1'b1 || fw1_data !== 32'd2) begin errors++; $display("FAIL young_fw act=%b/%h req=1/2", fw1_hit, fw1_data); end
    idle();
    tick();
    checks++; if (rd_wen !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'd1) begin errors++; $display("FAIL young_w1 act=%b/%0d/%h req=1/3/1", rd_wen, rd_addr, rd_data); end
    checks++; if (fw1_data !== 32'd2) begin errors++; $display("FAIL young_fw_mid act=%h req=2", fw1_data); end
    tick();
    checks++; if (rd_wen !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 32'd2) begin errors++; $display("FAIL young_w2 act=%b/%0d/%h req=1/3/2", rd_wen, rd_addr, rd_data); end
    // Same-cycle LSU is older than the ALU write and gets killed.
    fw2_addr = 5'd9;
    set_in(1'b1, 5'd9, 32'hC, 1'b1, 5'd9, 32'h99);
    tick();
    checks++; if (rd_wen !== 1'b1 || rd_addr !== 5'd9 || rd_data !== 32'hC) begin errors++; $display("FAIL same_alu act=%b/%0d/%h req=1/9/c", rd_wen, rd_addr, rd_data); end
    checks++; if (fw2_hit !== 1'b1 || fw2_data !== 32'hC) begin errors++; $display("FAIL same_fw act=%b/%h req=1/c", fw2_hit, fw2_data); end
    idle();
    tick();
    checks++; if (rd_wen !== 1'b0 || rd_data !== 32'hC) begin errors++; $display("FAIL same_skip act=%b/%h req=0/c", rd_wen, rd_data); end
  endtask

  task automatic test_x0_and_reset();
    fw1_addr = 5'd0;
    set_in(1'b1, 5'd0, 32'h55, 1'b1, 5'd0, 32'h66);
    tick();
    checks++; if (rd_wen !== 1'b0 || lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_nowrite act=%b/%b req=0/1", rd_wen, lsu_ready); end
    checks++; if (fw1_hit !== 1'b0) begin errors++; $display("FAIL x0_fw act=%b req=0", fw1_hit); end
    idle();
    tick();
    checks++; if (rd_wen !== 1'b0) begin errors++; $display("FAIL x0_dropped act=%b req=0", rd_wen); end
    // Queue three entries behind ALU traffic, then reset.
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 5'(1 + i), 32'h10 + i, 1'b1, 5'(4 + i), 32'h40 + i);
      tick();
    end
    fw1_addr = 5'd4; #1;
    checks++; if (fw1_hit !== 1'b1 || fw1_data !== 32'h40) begin errors++; $display("FAIL rst_pre_fw act=%b/%h req=1/40", fw1_hit, fw1_data); end
    idle(); reset = 1'b1; #1;
    checks++; if (lsu_ready !== 1'b0 || fw1_hit !== 1'b0) begin errors++; $display("FAIL rst_mid_gate act=%b/%b req=0/0", lsu_ready, fw1_hit); end
    tick();
    checks++; if (rd_wen !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin errors++; $display("FAIL rst_mid_out act=%b/%0d/%h req=0/0/0", rd_wen, rd_addr, rd_data); end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (rd_wen !== 1'b0 || fw1_hit !== 1'b0 || wb_full !== 1'b0) begin errors++; $display("FAIL rst_flush%0d act=%b/%b/%b req=0/0/0", i, rd_wen, fw1_hit, wb_full); end
    end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_lsu_single();
    test_fill_drain();
    test_kill();
    test_youngest();
    test_x0_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
